// File: rtl/Tipos.sv
// rtl/Tipos.sv - shared packet type, key codes and special packets for the password stages
package Tipos;

  localparam int NUM_DIGITOS = 20;

  // Digit 0 is the most recent key; older digits move toward index 19.
  typedef struct packed {
    logic [NUM_DIGITOS-1:0][3:0] digits;
  } senhaPac_t;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  localparam senhaPac_t PAC_VAZIO   = senhaPac_t'({NUM_DIGITOS{4'hF}});
  localparam senhaPac_t PAC_ESC     = senhaPac_t'({NUM_DIGITOS{4'hB}});
  localparam senhaPac_t PAC_TIMEOUT = senhaPac_t'({NUM_DIGITOS{4'hE}});

  // Shift one digit into position 0, dropping the oldest digit.
  function automatic senhaPac_t desloca_digito(senhaPac_t pac, logic [3:0] digito);
    senhaPac_t r;
    r.digits = {pac.digits[NUM_DIGITOS-2:0], digito};
    return r;
  endfunction

endpackage

// File: rtl/temporizador_inatividade.sv
// rtl/temporizador_inatividade.sv - clearable inactivity counter with a one-cycle expiry flag
module temporizador_inatividade #(
  parameter int TIMEOUT_CYCLES = 10_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expirou
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMITE = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cont_q;
  logic [W-1:0] cont_d;

  // Expiry is only meaningful on a cycle that would otherwise count.
  assign expirou = inc_i && (cont_q == LIMITE);

  // Clear wins; expiry wraps the counter so the flag lasts a single cycle.
  always_comb begin
    cont_d = cont_q;
    if (clr_i || expirou) begin
      cont_d = '0;
    end else if (inc_i) begin
      cont_d = cont_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

endmodule

// File: rtl/coletor_digitos.sv
// rtl/coletor_digitos.sv - keypad digit collector; inactivity timeout built only with COLETOR_TIMEOUT_EN
module coletor_digitos
  import Tipos::*;
#(
  parameter int TIMEOUT_CYCLES = 10_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output senhaPac_t  digitos_value,
  output logic       digitos_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } estado_t;

  localparam logic [4:0] MAX_CONT = 5'(NUM_DIGITOS);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_invalido
    $error("coletor_digitos: TIMEOUT_CYCLES must be at least 2");
  end

  estado_t    estado_q;
  senhaPac_t  buffer_q;
  logic       valid_q;
  logic [4:0] count_q;

  logic eh_digito;
  logic eh_estrela;
  logic eh_cerquilha;
  logic digito_cabe;
  logic timeout;

  assign eh_digito    = key_valid && (key_code <= 4'd9);
  assign eh_estrela   = key_valid && (key_code == KEY_STAR);
  assign eh_cerquilha = key_valid && (key_code == KEY_HASH);
  // A digit beyond the 20th is treated as if no key had been pressed.
  assign digito_cabe  = eh_digito && (count_q < MAX_CONT);

`ifdef COLETOR_TIMEOUT_EN
  logic tecla_aceita;
  logic timer_clr;
  logic timer_inc;

  assign tecla_aceita = digito_cabe || eh_estrela || eh_cerquilha;
  assign timer_inc    = enable && (estado_q == COLLECT) && !tecla_aceita;
  assign timer_clr    = !enable || (estado_q != COLLECT) || tecla_aceita;

  temporizador_inatividade #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_temporizador (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (timer_clr),
    .inc_i  (timer_inc),
    .expirou(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Collector FSM: buffer, digit count and the registered final-packet strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= IDLE;
      buffer_q <= PAC_VAZIO;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      if ((estado_q == EMIT) || !enable) begin
        // The strobe cycle has already been presented; keys here are dropped.
        estado_q <= IDLE;
        buffer_q <= PAC_VAZIO;
        count_q  <= '0;
      end else begin
        case (estado_q)
          IDLE: begin
            if (eh_digito) begin
              buffer_q <= desloca_digito(PAC_VAZIO, key_code);
              count_q  <= 5'd1;
              estado_q <= COLLECT;
            end else if (eh_cerquilha) begin
              buffer_q <= PAC_VAZIO;
              valid_q  <= 1'b1;
              estado_q <= EMIT;
            end else if (eh_estrela) begin
              buffer_q <= PAC_ESC;
              valid_q  <= 1'b1;
              estado_q <= EMIT;
            end
          end
          COLLECT: begin
            if (digito_cabe) begin
              buffer_q <= desloca_digito(buffer_q, key_code);
              count_q  <= count_q + 5'd1;
            end else if (eh_cerquilha) begin
              valid_q  <= 1'b1;
              estado_q <= EMIT;
            end else if (eh_estrela) begin
              buffer_q <= PAC_VAZIO;
              count_q  <= '0;
              estado_q <= IDLE;
            end else if (timeout) begin
              buffer_q <= PAC_TIMEOUT;
              valid_q  <= 1'b1;
              estado_q <= EMIT;
            end
          end
          default: begin
            estado_q <= IDLE;
            buffer_q <= PAC_VAZIO;
            count_q  <= '0;
          end
        endcase
      end
    end
  end

  assign digitos_value = buffer_q;
  assign digitos_valid = valid_q;

endmodule
